wb_commit_arb: RTL

Writeback/commit arbiter on the release side of the per-warp register scoreboard. Collects completed-instruction results from several execution sources (scalar ALU, SFU, LSU, ...), buffers each in a small per-source FIFO, picks one per cycle round-robin, and drives the single register-file write port plus the scoreboard's `commit_valid/commit_warp/commit_dst` release interface. Sits between execution-unit result buses and the register file/scoreboard in each shader-core sub-partition.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_src_fifo.sv | 58 +++++
 rtl/wb_commit_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and width helpers for the writeback/commit arbiter slice.
package wb_pkg;

  localparam int WB_NUM_WARPS = 32;
  localparam int WB_REG_ID_W  = 7;
  localparam int WB_DATA_W    = 32;

  function automatic int warp_w(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  // Count must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int WB_WARP_W = warp_w(WB_NUM_WARPS);

  typedef struct packed {
    logic [WB_WARP_W-1:0]   warp;
    logic [WB_REG_ID_W-1:0] dst;
    logic [WB_DATA_W-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO: wrapping pointers plus an explicit occupancy count.
module wb_src_fifo
  import wb_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [cnt_w(DEPTH)-1:0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  // DEPTH is a power of two, so pointer increment wraps for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_commit_arb.sv
// Round-robin writeback/commit arbiter feeding the RF write port and scoreboard release.
// WB_COMMIT_ARB_BYPASS_EN: an empty-FIFO source may win with its live input (1-cycle latency).
module wb_commit_arb
  import wb_pkg::*;
#(
  parameter int NUM_WARPS  = 32,
  parameter int REG_ID_W   = 7,
  parameter int DATA_W     = 32,
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int WARP_W    = warp_w(NUM_WARPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  input  logic [NUM_SRC*WARP_W-1:0]    src_warp_i,
  input  logic [NUM_SRC*REG_ID_W-1:0]  src_dst_i,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data_i,
  output logic                         commit_valid_o,
  input  logic                         commit_ready_i,
  output logic [WARP_W-1:0]            commit_warp_o,
  output logic [REG_ID_W-1:0]          commit_dst_o,
  output logic [DATA_W-1:0]            commit_data_o,
  output logic                         wb_idle_o
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CW    = cnt_w(FIFO_DEPTH);

  typedef struct packed {
    logic [WARP_W-1:0]   warp;
    logic [REG_ID_W-1:0] dst;
    logic [DATA_W-1:0]   data;
  } entry_t;

  entry_t                        in_e [NUM_SRC];
  entry_t                        fifo_rd [NUM_SRC];
  entry_t                        head [NUM_SRC];
  logic [NUM_SRC-1:0]            acc, push, pop, byp, cand, full, empty;
  logic [NUM_SRC-1:0][CW-1:0]    cnt;

  logic                          load, win_vld;
  logic [SRC_W-1:0]              win_idx, rr_q, rr_d;
  logic                          cv_q;
  entry_t                        out_q;

  assign load = ~cv_q | commit_ready_i;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign in_e[k] = '{warp: src_warp_i[k*WARP_W +: WARP_W],
                       dst:  src_dst_i[k*REG_ID_W +: REG_ID_W],
                       data: src_data_i[k*DATA_W +: DATA_W]};
    assign src_ready_o[k] = ~full[k];
    assign acc[k]         = src_valid_i[k] & ~full[k];
`ifdef WB_COMMIT_ARB_BYPASS_EN
    assign cand[k] = ~empty[k] | acc[k];
    assign head[k] = empty[k] ? in_e[k] : fifo_rd[k];
    assign byp[k]  = empty[k] & load & win_vld & (win_idx == SRC_W'(k));
`else
    assign cand[k] = ~empty[k];
    assign head[k] = fifo_rd[k];
    assign byp[k]  = 1'b0;
`endif
    assign push[k] = acc[k] & ~byp[k];
    assign pop[k]  = load & win_vld & (win_idx == SRC_W'(k)) & ~empty[k];

    wb_src_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[k]),
      .wdata_i (in_e[k]),
      .pop_i   (pop[k]),
      .rdata_o (fifo_rd[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .count_o (cnt[k])
    );
  end

  // First candidate at or after rr_q, ascending modulo NUM_SRC.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int j;
      j = (int'(rr_q) + i) % NUM_SRC;
      if (!win_vld && cand[j]) begin
        win_vld = 1'b1;
        win_idx = SRC_W'(j);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (load && win_vld)
      rr_d = (int'(win_idx) == NUM_SRC - 1) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cv_q  <= 1'b0;
      out_q <= '0;
      rr_q  <= '0;
    end else begin
      rr_q <= rr_d;
      if (load) begin
        cv_q <= win_vld;
        if (win_vld) out_q <= head[win_idx];
      end
    end
  end

  assign commit_valid_o = cv_q;
  assign commit_warp_o  = out_q.warp;
  assign commit_dst_o   = out_q.dst;
  assign commit_data_o  = out_q.data;
  assign wb_idle_o      = ~(|cnt) & ~cv_q;

endmodule
